spmv_fp16_row_acc: RTL and testbench



---
 rtl/spmv_fp16_row_acc.sv | 181 ++++++++++++++++++
 tb/tb_spmv_fp16_row_acc.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spmv_fp16_row_acc.sv
// Row accumulator for the SpMV fp16 pipeline: sums one CSR row's products
// with a four-cycle sequential fp16 adder and emits the rounded sum with its row index.
`timescale 1ns/1ps
module spmv_fp16_row_acc #(
    parameter int unsigned ROW_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [15:0]      i_prod,
    input  logic             i_last,
    output logic             o_ready,
    output logic             o_valid,
    output logic [15:0]      o_sum,
    output logic [ROW_W-1:0] o_row,
    input  logic             i_out_ready
);
    localparam int unsigned MW = 14;  // hidden bit + 10 fraction bits + guard/round/sticky
    localparam logic [15:0] QNAN = 16'h7E00;

    typedef enum logic [1:0] {IDLE, ALIGN, ADD, NORM} state_t;
    state_t state, state_nxt;
    logic   accept;

    logic [15:0]      acc, prod_q;
    logic             last_q;
    logic [ROW_W-1:0] row_cnt;

    logic [MW-1:0] big_q, sml_q;
    logic [4:0]    exp_q;
    logic          sign_q, sub_q, spec_q;
    logic [15:0]   spec_val_q;
    logic [MW:0]   sum_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ALIGN;
            ALIGN:   state_nxt = ADD;
            ADD:     state_nxt = NORM;
            NORM:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_ready = (state == IDLE) && !o_valid;
    end

    assign accept = i_valid && o_ready;

    // Alignment: order operands by magnitude and shift the smaller into G/R/S.
    logic [4:0]    a_exp, b_exp, diff_c, big_exp_c;
    logic [MW-1:0] a_sig, b_sig, big_c, sml_c, sml_sh_c, mask_c;
    logic          a_nan, a_inf, b_nan, b_inf, a_big_c, big_sign_c;
    logic [15:0]   spec_val_c;
    always_comb begin
        a_exp      = acc[14:10];
        b_exp      = prod_q[14:10];
        a_sig      = (a_exp == 5'd0) ? '0 : {1'b1, acc[9:0], 3'b000};
        b_sig      = (b_exp == 5'd0) ? '0 : {1'b1, prod_q[9:0], 3'b000};
        a_nan      = (&a_exp) && (|acc[9:0]);
        a_inf      = (&a_exp) && !(|acc[9:0]);
        b_nan      = (&b_exp) && (|prod_q[9:0]);
        b_inf      = (&b_exp) && !(|prod_q[9:0]);
        a_big_c    = {a_exp, a_sig} >= {b_exp, b_sig};
        big_c      = a_big_c ? a_sig : b_sig;
        sml_c      = a_big_c ? b_sig : a_sig;
        big_exp_c  = a_big_c ? a_exp : b_exp;
        big_sign_c = a_big_c ? acc[15] : prod_q[15];
        diff_c     = a_big_c ? (a_exp - b_exp) : (b_exp - a_exp);
        mask_c     = '0;
        if (diff_c >= 5'd14) begin
            sml_sh_c = {{(MW-1){1'b0}}, |sml_c};
        end else begin
            mask_c      = (MW'(1) << diff_c) - MW'(1);
            sml_sh_c    = sml_c >> diff_c;
            sml_sh_c[0] = sml_sh_c[0] | (|(sml_c & mask_c));
        end
        if (a_nan || b_nan || (a_inf && b_inf && (acc[15] != prod_q[15]))) spec_val_c = QNAN;
        else if (a_inf) spec_val_c = {acc[15], 15'h7C00};
        else            spec_val_c = {prod_q[15], 15'h7C00};
    end

    // Normalisation and round-to-nearest-even.
    logic [3:0]        lz_c;
    logic              found_c, rnd_up_c;
    logic [MW-1:0]     m_c;
    logic signed [6:0] e_c;
    logic [11:0]       mant_c;
    logic [15:0]       res_c;
    always_comb begin
        lz_c    = '0;
        found_c = 1'b0;
        for (int i = MW-1; i >= 0; i--) begin
            if (!found_c) begin
                if (sum_q[i]) found_c = 1'b1;
                else          lz_c    = lz_c + 4'd1;
            end
        end
        if (sum_q[MW]) begin
            m_c    = sum_q[MW:1];
            m_c[0] = m_c[0] | sum_q[0];
            e_c    = $signed({2'b00, exp_q}) + 7'sd1;
        end else begin
            m_c = sum_q[MW-1:0] << lz_c;
            e_c = $signed({2'b00, exp_q}) - $signed({3'b000, lz_c});
        end
        rnd_up_c = m_c[2] && (m_c[1] || m_c[0] || m_c[3]);
        mant_c   = {1'b0, m_c[MW-1:3]} + 12'(rnd_up_c);
        if (mant_c[11]) begin
            mant_c = mant_c >> 1;
            e_c    = e_c + 7'sd1;
        end
        if (spec_q)                                  res_c = spec_val_q;
        else if ((sum_q == '0) || (e_c <= 7'sd0))    res_c = 16'h0000;
        else if (e_c >= 7'sd31)                      res_c = {sign_q, 15'h7C00};
        else                                         res_c = {sign_q, e_c[4:0], mant_c[9:0]};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            prod_q     <= '0;
            last_q     <= 1'b0;
            big_q      <= '0;
            sml_q      <= '0;
            exp_q      <= '0;
            sign_q     <= 1'b0;
            sub_q      <= 1'b0;
            spec_q     <= 1'b0;
            spec_val_q <= '0;
            sum_q      <= '0;
        end else begin
            if (accept) begin
                prod_q <= i_prod;
                last_q <= i_last;
            end
            if (state == ALIGN) begin
                big_q      <= big_c;
                sml_q      <= sml_sh_c;
                exp_q      <= big_exp_c;
                sign_q     <= big_sign_c;
                sub_q      <= acc[15] ^ prod_q[15];
                spec_q     <= (&a_exp) || (&b_exp);
                spec_val_q <= spec_val_c;
            end
            if (state == ADD) begin
                sum_q <= sub_q ? ({1'b0, big_q} - {1'b0, sml_q}) : ({1'b0, big_q} + {1'b0, sml_q});
            end
        end
    end

    // Accumulator writeback and row completion.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc     <= '0;
            o_sum   <= '0;
            o_row   <= '0;
            o_valid <= 1'b0;
            row_cnt <= '0;
        end else begin
            if (o_valid && i_out_ready) o_valid <= 1'b0;
            if (state == NORM) begin
                if (last_q) begin
                    o_sum   <= res_c;
                    o_row   <= row_cnt;
                    o_valid <= 1'b1;
                    acc     <= '0;
                    row_cnt <= row_cnt + ROW_W'(1);
                end else begin
                    acc <= res_c;
                end
            end
        end
    end
endmodule

// File: tb/tb_spmv_fp16_row_acc.sv
// Self-checking bench for spmv_fp16_row_acc: directed rows plus random rows
// checked against an exact-integer fp16 summation model.
`timescale 1ns/1ps
module tb_spmv_fp16_row_acc;
    localparam int unsigned ROW_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_valid, i_last, i_out_ready;
    logic [15:0]      i_prod;
    logic             o_ready, o_valid;
    logic [15:0]      o_sum;
    logic [ROW_W-1:0] o_row;

    int n_cmp = 0;
    int n_err = 0;
    int exp_row = 0;
    logic [15:0] rowq[$];

    spmv_fp16_row_acc #(.ROW_W(ROW_W)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .i_prod(i_prod), .i_last(i_last),
        .o_ready(o_ready), .o_valid(o_valid), .o_sum(o_sum), .o_row(o_row),
        .i_out_ready(i_out_ready)
    );

    always #5 clk = ~clk;

    // Exact value in units of 2^-24; subnormals read as zero.
    function automatic longint to_fix(input logic [15:0] h);
        longint m;
        if (h[14:10] == 5'd0) return 0;
        m = longint'({1'b1, h[9:0]}) << (int'(h[14:10]) - 1);
        return h[15] ? -m : m;
    endfunction

    function automatic logic [15:0] from_fix(input longint v);
        logic   sgn;
        longint mag, q, rem, half;
        int     p, e, sh;
        if (v == 0) return 16'h0000;
        sgn = (v < 0);
        mag = sgn ? -v : v;
        p = 0;
        for (int i = 0; i < 62; i++) if (mag[i]) p = i;
        e = p - 9;
        if (e <= 0) return 16'h0000;
        sh = p - 10;
        q  = mag >> sh;
        if (sh > 0) begin
            rem  = mag - (q << sh);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
        end
        if (q == 2048) begin q = 1024; e = e + 1; end
        if (e >= 31) return sgn ? 16'hFC00 : 16'h7C00;
        return {sgn, 5'(e), 10'(q)};
    endfunction

    function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
        logic an, ai, bn, bi;
        an = (a[14:10] == 5'h1F) && (a[9:0] != 0);
        ai = (a[14:10] == 5'h1F) && (a[9:0] == 0);
        bn = (b[14:10] == 5'h1F) && (b[9:0] != 0);
        bi = (b[14:10] == 5'h1F) && (b[9:0] == 0);
        if (an || bn) return 16'h7E00;
        if (ai && bi) return (a[15] == b[15]) ? a : 16'h7E00;
        if (ai) return a;
        if (bi) return b;
        return from_fix(to_fix(a) + to_fix(b));
    endfunction

    function automatic logic [15:0] ref_row();
        logic [15:0] s = 16'h0000;
        foreach (rowq[i]) s = ref_add(s, rowq[i]);
        return s;
    endfunction

    function automatic logic [15:0] rand_fp16();
        logic [15:0] sp [6] = '{16'h7C00, 16'hFC00, 16'h7D11, 16'h0003, 16'h8000, 16'h0000};
        int r = $urandom_range(0, 15);
        if (r == 0) return sp[$urandom_range(0, 5)];
        if (r == 1) return {1'($urandom), 5'($urandom_range(28, 30)), 10'($urandom)};
        return {1'($urandom), 5'($urandom_range(12, 18)), 10'($urandom)};
    endfunction

    task automatic set_row(input logic [15:0] a, input logic [15:0] b, input int len);
        rowq.delete();
        rowq.push_back(a);
        if (len > 1) rowq.push_back(b);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_valid = 1'b0; i_prod = '0; i_last = 1'b0; i_out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_row = 0;
        @(negedge clk);
    endtask

    // Present one product from a negedge; returns at the negedge after its accept edge.
    task automatic send(input logic [15:0] p, input logic l);
        int n = 0;
        i_valid = 1'b1; i_prod = p; i_last = l;
        while (!o_ready && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic run_row(input int stall, output logic [15:0] s, output logic [ROW_W-1:0] r,
                           output bit ok);
        int n = 0;
        i_out_ready = 1'b0;
        foreach (rowq[i]) send(rowq[i], (i == rowq.size() - 1));
        while (!o_valid && n < 50) begin @(negedge clk); n++; end
        ok = o_valid;
        repeat (stall) @(negedge clk);
        s = o_sum; r = o_row;
        i_out_ready = 1'b1;
        @(negedge clk);
        exp_row = (exp_row + 1) % 256;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (o_valid !== 1'b0 || o_sum !== 16'h0 || o_row !== '0 || o_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset: valid=%b sum=%h row=%0d ready=%b, want 0 0000 0 1", o_valid, o_sum, o_row, o_ready);
        end
    endtask

    task automatic test_basic_row();
        logic v[4];
        do_reset();
        send(16'h4D40, 1'b0);
        send(16'h4D40, 1'b1);
        for (int k = 1; k <= 3; k++) begin @(negedge clk); v[k] = o_valid; end
        n_cmp++;
        if (v[1] !== 1'b0 || v[2] !== 1'b0 || v[3] !== 1'b1) begin
            n_err++;
            $display("FAIL basic_latency: valid after edges 1..3 = %b%b%b, want 001", v[1], v[2], v[3]);
        end
        n_cmp++;
        if (o_sum !== 16'h5140 || o_row !== 8'd0) begin
            n_err++;
            $display("FAIL basic_sum: got %h row %0d, want 5140 row 0", o_sum, o_row);
        end
        @(negedge clk);
        exp_row = 1;
    endtask

    task automatic test_cancel_sign();
        logic [15:0] s; logic [ROW_W-1:0] r; bit ok; int er;
        logic [15:0] a [2] = '{16'h3C00, 16'h4000};
        logic [15:0] b [2] = '{16'hBC00, 16'hC200};
        logic [15:0] w [2] = '{16'h0000, 16'hBC00};
        for (int k = 0; k < 2; k++) begin
            set_row(a[k], b[k], 2);
            er = exp_row;
            run_row(0, s, r, ok);
            n_cmp++;
            if (!ok || s !== w[k] || r !== ROW_W'(er)) begin
                n_err++;
                $display("FAIL cancel_sign[%0d]: got %h row %0d ok=%0d, want %h row %0d", k, s, r, ok, w[k], er);
            end
        end
    endtask

    task automatic test_rounding();
        logic [15:0] s; logic [ROW_W-1:0] r; bit ok;
        logic [15:0] b [2] = '{16'h3C00, 16'h4200};
        logic [15:0] w [2] = '{16'h6800, 16'h6802};
        for (int k = 0; k < 2; k++) begin
            set_row(16'h6800, b[k], 2);
            run_row(0, s, r, ok);
            n_cmp++;
            if (!ok || s !== w[k]) begin
                n_err++;
                $display("FAIL rounding[%0d]: got %h, want %h", k, s, w[k]);
            end
        end
    endtask

    task automatic test_specials();
        logic [15:0] s; logic [ROW_W-1:0] r; bit ok;
        logic [15:0] a [6] = '{16'h7BFF, 16'h7C00, 16'h0001, 16'h7C01, 16'h7D00, 16'hFC00};
        logic [15:0] b [6] = '{16'h7BFF, 16'hFC00, 16'h0000, 16'h3C00, 16'h0000, 16'h4000};
        int          l [6] = '{2, 2, 1, 2, 1, 2};
        logic [15:0] w [6] = '{16'h7C00, 16'h7E00, 16'h0000, 16'h7E00, 16'h7E00, 16'hFC00};
        for (int k = 0; k < 6; k++) begin
            set_row(a[k], b[k], l[k]);
            run_row(0, s, r, ok);
            n_cmp++;
            if (!ok || s !== w[k]) begin
                n_err++;
                $display("FAIL specials[%0d]: got %h, want %h", k, s, w[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] s; logic [ROW_W-1:0] r; bit ok; int n = 0; int bad = 0; int er;
        er = exp_row;
        i_out_ready = 1'b0;
        send(16'h4D40, 1'b1);
        while (!o_valid && n < 50) begin @(negedge clk); n++; end
        n_cmp++;
        if (o_valid !== 1'b1 || o_sum !== 16'h4D40 || o_row !== ROW_W'(er)) begin
            n_err++;
            $display("FAIL bp_result: valid=%b sum=%h row=%0d, want 1 4D40 %0d", o_valid, o_sum, o_row, er);
        end
        exp_row = (exp_row + 1) % 256;
        i_valid = 1'b1; i_prod = 16'h7C01; i_last = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (o_valid !== 1'b1 || o_sum !== 16'h4D40 || o_ready !== 1'b0) bad++;
        end
        i_valid = 1'b0;
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL bp_hold: %0d of 10 cycles unstable, want 0", bad);
        end
        i_out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release: valid=%b ready=%b, want 0 1", o_valid, o_ready);
        end
        set_row(16'h3C00, 16'h0000, 1);
        er = exp_row;
        run_row(0, s, r, ok);
        n_cmp++;
        if (!ok || s !== 16'h3C00 || r !== ROW_W'(er)) begin
            n_err++;
            $display("FAIL bp_next_row: got %h row %0d, want 3C00 row %0d", s, r, er);
        end
    endtask

    task automatic test_row_wrap();
        logic [15:0] s; logic [ROW_W-1:0] r; bit ok; int er;
        do_reset();
        set_row(16'h3C00, 16'h0000, 1);
        for (int k = 0; k < 257; k++) begin
            er = exp_row;
            run_row(0, s, r, ok);
            n_cmp++;
            if (!ok || r !== ROW_W'(er) || s !== 16'h3C00) begin
                n_err++;
                $display("FAIL row_wrap[%0d]: got row %0d sum %h, want row %0d sum 3C00", k, r, s, er);
            end
        end
    endtask

    task automatic test_reset_mid_row();
        logic [15:0] s; logic [ROW_W-1:0] r; bit ok;
        i_out_ready = 1'b1;
        send(16'h4D40, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (o_valid !== 1'b0 || o_sum !== 16'h0 || o_row !== '0 || o_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid: valid=%b sum=%h row=%0d ready=%b, want 0 0000 0 1", o_valid, o_sum, o_row, o_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_row = 0;
        @(negedge clk);
        set_row(16'h3C00, 16'h0000, 1);
        run_row(0, s, r, ok);
        n_cmp++;
        if (!ok || s !== 16'h3C00 || r !== 8'd0) begin
            n_err++;
            $display("FAIL reset_mid_next: got %h row %0d, want 3C00 row 0", s, r);
        end
    endtask

    task automatic test_random();
        logic [15:0] s, w; logic [ROW_W-1:0] r; bit ok; int er; int len;
        do_reset();
        for (int k = 0; k < 60; k++) begin
            len = $urandom_range(1, 4);
            rowq.delete();
            for (int j = 0; j < len; j++) rowq.push_back(rand_fp16());
            w  = ref_row();
            er = exp_row;
            run_row($urandom_range(0, 3), s, r, ok);
            n_cmp++;
            if (!ok || s !== w || r !== ROW_W'(er)) begin
                n_err++;
                $display("FAIL random[%0d]: len %0d got %h row %0d ok=%0d, want %h row %0d",
                         k, len, s, r, ok, w, er);
            end
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic_row();
        test_cancel_sign();
        test_rounding();
        test_specials();
        test_backpressure();
        test_row_wrap();
        test_reset_mid_row();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
